pipe_out_arbiter: RTL and testbench
===================================

# pipe_out_arbiter

Round-robin arbiter that shares one outbound tagged pipe (`enq` method, ENA/RDY handshake) among NREQ method-level requesters. Each requester's payload is buffered in a one-entry slot, tagged with the requester's message tag, and forwarded through a registered output stage. A downstream tag demultiplexer dispatches on that tag to the matching request method. The block is the transmit-side counterpart of the per-interface input demultiplexers and sits between generated indication proxies and the shared transport pipe.

## Interface
- NREQ, 4: number of requesters, legal range 2..8.
- DATA_WIDTH, 64: payload bits per message.
- TAG_WIDTH, 16: tag field width.
- TAG_BASE, 1: tag assigned to requester 0. Requester i uses tag TAG_BASE+i, so tag 0 is never emitted.
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  reset, synchronous, active-low.
- in_enq__ENA  in  NREQ  per-requester enqueue fire. Legal only while the matching RDY bit is high.
- in_enq__RDY  out  NREQ  per-requester slot empty.
- in_enq$v  in  NREQ*DATA_WIDTH  payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_enq__ENA  out  1  output fire.
- out_enq__RDY  in  1  downstream can accept.
- out_enq$v  out  TAG_WIDTH+DATA_WIDTH  {tag, data}; tag in the upper TAG_WIDTH bits.
- sent_count  out  32  messages delivered downstream.

## Operation
- State:
  - NREQ slots, each a valid bit plus DATA_WIDTH payload.
  - Output stage: out_valid, a tag and a payload.
  - Round-robin pointer last_grant, log2(NREQ) bits.
  - 32-bit sent_count.
- Reset values: all slot valids 0, out_valid 0, last_grant = NREQ-1 (requester 0 wins first), sent_count 0. Payload registers hold don't-care values.
- in_enq__RDY[i] = !slot_valid[i]. This is registered state only; there is no combinational path from in_enq__ENA or out_enq__RDY.
- Slot capture: when in_enq__ENA[i] is high and the slot is empty, the slot loads its payload and becomes valid at the next edge. If ENA is high while the slot is full, this is a protocol violation: the request is ignored and the stored payload is unchanged.
- Output fire: out_enq__ENA = out_valid && out_enq__RDY. When it fires, out_valid clears at the edge unless the stage is refilled in the same cycle, and sent_count increments, wrapping from 2^32-1 to 0.
- Grant condition: the output stage can load when it is empty or firing this cycle (!out_valid || out_enq__ENA).
- Grant selection: the winner is the first valid slot in the order last_grant+1, last_grant+2, … modulo NREQ.
- On a grant to winner w:
  - the output stage loads {TAG_BASE+w truncated to TAG_WIDTH, slot_w payload};
  - slot_valid[w] clears;
  - last_grant becomes w.
- No grant: last_grant is unchanged when no slot is valid or the output stage is full and stalled.
- A slot cleared by a grant reports RDY the next cycle. It cannot be refilled in the same cycle it is granted.
- Reset mid-operation: with nRST low at an edge, all state returns to reset values and buffered messages are dropped. While nRST is low, in_enq__ENA is ignored and out_enq__ENA is forced 0.

## Timing
- Latency: requester ENA in cycle 0 → slot valid in cycle 1 → granted at the cycle-1 edge → out_enq__ENA in cycle 2 if out_enq__RDY is high.
- Throughput:
  - aggregate, with two or more requesters active: 1 message/cycle;
  - single requester: 1 message per 2 cycles, because a granted slot refills a cycle later.
- Backpressure: while out_enq__RDY is low, out_enq$v is held stable and no grant occurs. Slots fill and drop RDY, with no loss.
- Fairness: among continuously valid requesters, each receives exactly one grant per NREQ grants.
- Ordering: per-requester order is preserved. Cross-requester order is round-robin, not arrival order.

## Test plan
- Reset: hold nRST low 3 cycles with all ENA high → after release, in_enq__RDY = 4'b1111, out_enq__ENA = 0, sent_count = 0.
- Single message: requester 2 enqueues 0xDEADBEEF in cycle 0 with out_enq__RDY = 1 → out_enq__ENA in cycle 2 with out_enq$v = {16'd3, 64'hDEADBEEF}; sent_count = 1 afterward.
- Fairness: all 4 requesters always enqueue with out_enq__RDY = 1 → grant tag sequence 1,2,3,4,1,2,…; over 400 deliveries each tag appears 100 times.
- Backpressure: hold out_enq__RDY low for 10 cycles while all requesters offer data → out_enq$v is stable, all in_enq__RDY drop to 0, and after release all 5 buffered messages (1 staged + 4 slots) arrive intact.
- Protocol violation: ENA to a full slot with a new payload → the original payload is delivered and the new one is never emitted.
- Reset mid-stream: assert nRST with 3 slots and the output stage full → no out_enq__ENA after reset, and the next message gets tag 1 (TAG_BASE) if requester 0 is valid.

Source files
------------

// File: rtl/pipe_out_arbiter_if.sv
// rtl/pipe_out_arbiter_if.sv - per-requester enq inputs plus the shared tagged outbound pipe
interface pipe_out_arbiter_if #(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 16
);
  logic [NREQ-1:0]                 in_enq__ENA;
  logic [NREQ-1:0]                 in_enq__RDY;
  logic [NREQ*DATA_WIDTH-1:0]      in_enq_v;
  logic                            out_enq__ENA;
  logic                            out_enq__RDY;
  logic [TAG_WIDTH+DATA_WIDTH-1:0] out_enq_v;
  logic [31:0]                     sent_count;

  modport master (
    input  in_enq__ENA, in_enq_v, out_enq__RDY,
    output in_enq__RDY, out_enq__ENA, out_enq_v, sent_count
  );

  modport slave (
    output in_enq__ENA, in_enq_v, out_enq__RDY,
    input  in_enq__RDY, out_enq__ENA, out_enq_v, sent_count
  );
endinterface

// File: rtl/pipe_out_arbiter.sv
// rtl/pipe_out_arbiter.sv - round-robin arbiter of one-entry requester slots onto a tagged enq pipe
module pipe_out_arbiter #(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 16,
  parameter int TAG_BASE   = 1
) (
  input  logic                CLK,
  input  logic                nRST,
  pipe_out_arbiter_if.master  bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef logic [PW-1:0] idx_t;

  logic [NREQ-1:0]       slot_valid_q, slot_valid_d;
  logic [DATA_WIDTH-1:0] slot_data_q [NREQ];
  logic [DATA_WIDTH-1:0] slot_data_d [NREQ];
  logic [NREQ-1:0]       capture;

  logic                  out_valid_q, out_valid_d;
  logic [TAG_WIDTH-1:0]  out_tag_q, out_tag_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  idx_t                  last_grant_q, last_grant_d;
  logic [31:0]           sent_count_q, sent_count_d;

  logic                  fire;
  logic                  grant_ok;
  logic                  grant;
  logic                  found;
  idx_t                  winner;
  idx_t                  cand;

  // Fire is suppressed during reset so nothing leaks downstream while state is being cleared.
  assign fire     = out_valid_q && bus.out_enq__RDY && nRST;
  assign grant_ok = !out_valid_q || fire;
  assign grant    = grant_ok && found;

  // Walk the slots starting just after the previous winner; the first valid one wins.
  always_comb begin
    winner = last_grant_q;
    found  = 1'b0;
    cand   = last_grant_q;
    for (int k = 0; k < NREQ; k++) begin
      cand = (cand == idx_t'(NREQ - 1)) ? '0 : cand + 1'b1;
      if (!found && slot_valid_q[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // A slot only accepts while empty; writes to a full slot are dropped.
  always_comb begin
    slot_valid_d = slot_valid_q;
    for (int i = 0; i < NREQ; i++) begin
      capture[i]     = bus.in_enq__ENA[i] && !slot_valid_q[i] && nRST;
      slot_data_d[i] = capture[i] ? bus.in_enq_v[i*DATA_WIDTH +: DATA_WIDTH] : slot_data_q[i];
      if (grant && (winner == idx_t'(i))) begin
        slot_valid_d[i] = 1'b0;
      end else if (capture[i]) begin
        slot_valid_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_tag_d    = out_tag_q;
    out_data_d   = out_data_q;
    last_grant_d = last_grant_q;
    sent_count_d = sent_count_q;
    if (fire) begin
      out_valid_d  = 1'b0;
      sent_count_d = sent_count_q + 32'd1;
    end
    if (grant) begin
      out_valid_d  = 1'b1;
      out_tag_d    = TAG_WIDTH'(TAG_BASE + int'(winner));
      out_data_d   = slot_data_q[winner];
      last_grant_d = winner;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      slot_valid_q <= '0;
      out_valid_q  <= 1'b0;
      last_grant_q <= idx_t'(NREQ - 1);
      sent_count_q <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      out_valid_q  <= out_valid_d;
      last_grant_q <= last_grant_d;
      sent_count_q <= sent_count_d;
    end
  end

  // Payload registers carry no reset; they are only meaningful alongside their valid bits.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NREQ; i++) begin
      slot_data_q[i] <= slot_data_d[i];
    end
    out_tag_q  <= out_tag_d;
    out_data_q <= out_data_d;
  end

  assign bus.in_enq__RDY  = ~slot_valid_q;
  assign bus.out_enq__ENA = fire;
  assign bus.out_enq_v    = {out_tag_q, out_data_q};
  assign bus.sent_count   = sent_count_q;
endmodule

// File: tb/tb_pipe_out_arbiter.sv
// tb/tb_pipe_out_arbiter.sv - scenario tasks plus randomized per-requester scoreboard for pipe_out_arbiter
module tb_pipe_out_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 64;
  localparam int TW   = 16;

  logic CLK = 1'b0;
  logic nRST;

  pipe_out_arbiter_if #(.NREQ(NREQ), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

  pipe_out_arbiter #(.NREQ(NREQ), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .TAG_BASE(1)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q [NREQ][$];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_enq__ENA  = '0;
    bus.in_enq_v     = '0;
    bus.out_enq__RDY = 1'b1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    idle_inputs();
    tick();
    tick();
    nRST = 1'b1;
    for (int i = 0; i < NREQ; i++) exp_q[i].delete();
  endtask

  // Offer a fresh payload on every requester in mask whose slot reports ready.
  task automatic offer(input logic [NREQ-1:0] mask, output int pushed);
    logic [DW-1:0] d;
    pushed = 0;
    for (int i = 0; i < NREQ; i++) begin
      d = {$urandom, $urandom};
      bus.in_enq_v[i*DW +: DW] = d;
      if (mask[i] && bus.in_enq__RDY[i]) begin
        bus.in_enq__ENA[i] = 1'b1;
        exp_q[i].push_back(d);
        pushed++;
      end else begin
        bus.in_enq__ENA[i] = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    tick();
    nRST = 1'b0;
    bus.in_enq__ENA  = '1;
    bus.in_enq_v     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    bus.out_enq__RDY = 1'b1;
    repeat (3) tick();
    nRST = 1'b1;
    bus.in_enq__ENA = '0;
    @(negedge CLK);
    n_checks++;
    if (bus.in_enq__RDY !== 4'b1111) begin
      n_fail++; $display("FAIL reset_rdy: got %b expected 1111", bus.in_enq__RDY);
    end
    n_checks++;
    if (bus.out_enq__ENA !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_ena: got %b expected 0", bus.out_enq__ENA);
    end
    n_checks++;
    if (bus.sent_count !== 32'd0) begin
      n_fail++; $display("FAIL reset_sent_count: got %0d expected 0", bus.sent_count);
    end
    tick();
  endtask

  task automatic test_single();
    logic [TW+DW-1:0] want;
    want = {16'd3, 64'h00000000DEADBEEF};
    do_reset();
    bus.in_enq__ENA = 4'b0100;
    bus.in_enq_v[2*DW +: DW] = 64'hDEADBEEF;
    @(negedge CLK);
    n_checks++;
    if (bus.out_enq__ENA !== 1'b0) begin
      n_fail++; $display("FAIL single_c0_ena: got %b expected 0", bus.out_enq__ENA);
    end
    tick();
    bus.in_enq__ENA = '0;
    @(negedge CLK);
    n_checks++;
    if (bus.out_enq__ENA !== 1'b0 || bus.in_enq__RDY !== 4'b1011) begin
      n_fail++; $display("FAIL single_c1: got ena=%b rdy=%b expected ena=0 rdy=1011", bus.out_enq__ENA, bus.in_enq__RDY);
    end
    tick();
    @(negedge CLK);
    n_checks++;
    if (bus.out_enq__ENA !== 1'b1 || bus.out_enq_v !== want) begin
      n_fail++; $display("FAIL single_c2: got ena=%b v=%h expected ena=1 v=%h", bus.out_enq__ENA, bus.out_enq_v, want);
    end
    tick();
    @(negedge CLK);
    n_checks++;
    if (bus.sent_count !== 32'd1 || bus.out_enq__ENA !== 1'b0) begin
      n_fail++; $display("FAIL single_after: got count=%0d ena=%b expected count=1 ena=0", bus.sent_count, bus.out_enq__ENA);
    end
  endtask

  task automatic test_fairness();
    int cnt [NREQ];
    int n, cyc, first_cyc, last_cyc, r, pushed;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    for (int i = 0; i < NREQ; i++) cnt[i] = 0;
    n = 0; cyc = 0; first_cyc = -1; last_cyc = 0;
    do_reset();
    while (n < 400 && cyc < 2000) begin
      offer('1, pushed);
      @(negedge CLK);
      if (bus.out_enq__ENA === 1'b1) begin
        tag  = bus.out_enq_v[DW +: TW];
        data = bus.out_enq_v[DW-1:0];
        n_checks++;
        if (tag !== TW'((n % NREQ) + 1)) begin
          n_fail++; $display("FAIL fair_tag_seq[%0d]: got %0d expected %0d", n, tag, (n % NREQ) + 1);
        end
        r = int'(tag) - 1;
        if (r >= 0 && r < NREQ) begin
          cnt[r]++;
          n_checks++;
          if (exp_q[r].size() == 0) begin
            n_fail++; $display("FAIL fair_data: got %h from tag %0d expected nothing pending", data, tag);
          end else begin
            if (data !== exp_q[r][0]) begin
              n_fail++; $display("FAIL fair_data: got %h expected %h", data, exp_q[r][0]);
            end
            void'(exp_q[r].pop_front());
          end
        end
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        n++;
      end
      tick();
      cyc++;
    end
    bus.in_enq__ENA = '0;
    n_checks++;
    if (n != 400) begin
      n_fail++; $display("FAIL fair_timeout: got %0d deliveries expected 400", n);
    end
    for (int i = 0; i < NREQ; i++) begin
      n_checks++;
      if (cnt[i] != 100) begin
        n_fail++; $display("FAIL fair_count_tag%0d: got %0d expected 100", i + 1, cnt[i]);
      end
    end
    n_checks++;
    if (last_cyc - first_cyc != 399) begin
      n_fail++; $display("FAIL fair_throughput: got span %0d expected 399", last_cyc - first_cyc);
    end
  endtask

  task automatic test_backpressure();
    logic [TW+DW-1:0] staged;
    int pushed, n, r;
    int want_tags [5];
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    want_tags = '{1, 2, 3, 4, 1};
    staged = '0;
    do_reset();
    bus.out_enq__RDY = 1'b0;
    for (int c = 0; c < 10; c++) begin
      offer('1, pushed);
      @(negedge CLK);
      n_checks++;
      if (bus.out_enq__ENA !== 1'b0) begin
        n_fail++; $display("FAIL bp_no_fire c%0d: got %b expected 0", c, bus.out_enq__ENA);
      end
      if (c == 2) begin
        staged = bus.out_enq_v;
        n_checks++;
        if (staged[DW +: TW] !== 16'd1) begin
          n_fail++; $display("FAIL bp_staged_tag: got %0d expected 1", staged[DW +: TW]);
        end
      end else if (c > 2) begin
        n_checks++;
        if (bus.out_enq_v !== staged) begin
          n_fail++; $display("FAIL bp_stable c%0d: got %h expected %h", c, bus.out_enq_v, staged);
        end
      end
      if (c == 9) begin
        n_checks++;
        if (bus.in_enq__RDY !== 4'b0000) begin
          n_fail++; $display("FAIL bp_rdy_full: got %b expected 0000", bus.in_enq__RDY);
        end
      end
      tick();
    end
    bus.in_enq__ENA  = '0;
    bus.out_enq__RDY = 1'b1;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (bus.out_enq__ENA === 1'b1) begin
        tag  = bus.out_enq_v[DW +: TW];
        data = bus.out_enq_v[DW-1:0];
        n_checks++;
        if (n >= 5 || tag !== TW'(want_tags[n % 5])) begin
          n_fail++; $display("FAIL bp_tag[%0d]: got %0d expected %0d", n, tag, want_tags[n % 5]);
        end
        r = int'(tag) - 1;
        n_checks++;
        if (r < 0 || r >= NREQ || exp_q[r].size() == 0) begin
          n_fail++; $display("FAIL bp_data: got %h tag %0d expected a pending payload", data, tag);
        end else begin
          if (data !== exp_q[r][0]) begin
            n_fail++; $display("FAIL bp_data: got %h expected %h", data, exp_q[r][0]);
          end
          void'(exp_q[r].pop_front());
        end
        n++;
      end
      tick();
    end
    n_checks++;
    if (n != 5) begin
      n_fail++; $display("FAIL bp_total: got %0d expected 5", n);
    end
  endtask

  task automatic test_violation();
    logic [DW-1:0] xv, av;
    logic [DW-1:0] bv [4];
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    int n;
    xv = {$urandom, $urandom};
    av = {$urandom, $urandom};
    do_reset();
    bus.out_enq__RDY = 1'b0;
    bus.in_enq__ENA  = 4'b0011;
    bus.in_enq_v[0 +: DW]  = xv;
    bus.in_enq_v[DW +: DW] = av;
    tick();
    for (int k = 0; k < 4; k++) begin
      bv[k] = {$urandom, $urandom};
      if (bv[k] == av || bv[k] == xv) bv[k] = ~av ^ ~xv;
      n_checks++;
      if (bus.in_enq__RDY[1] !== 1'b0) begin
        n_fail++; $display("FAIL viol_slot_full k%0d: got rdy=%b expected 0", k, bus.in_enq__RDY[1]);
      end
      bus.in_enq__ENA = 4'b0010;
      bus.in_enq_v[DW +: DW] = bv[k];
      tick();
    end
    bus.in_enq__ENA  = '0;
    bus.out_enq__RDY = 1'b1;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (bus.out_enq__ENA === 1'b1) begin
        tag  = bus.out_enq_v[DW +: TW];
        data = bus.out_enq_v[DW-1:0];
        n_checks++;
        if (n == 0 && (tag !== 16'd1 || data !== xv)) begin
          n_fail++; $display("FAIL viol_first: got tag=%0d data=%h expected tag=1 data=%h", tag, data, xv);
        end else if (n == 1 && (tag !== 16'd2 || data !== av)) begin
          n_fail++; $display("FAIL viol_original: got tag=%0d data=%h expected tag=2 data=%h", tag, data, av);
        end else if (n > 1) begin
          n_fail++; $display("FAIL viol_extra: got tag=%0d data=%h expected no more messages", tag, data);
        end
        for (int k = 0; k < 4; k++) begin
          if (data === bv[k]) begin
            n_fail++; $display("FAIL viol_ignored_payload: got %h expected it never emitted", data);
          end
        end
        n++;
      end
      tick();
    end
    n_checks++;
    if (n != 2) begin
      n_fail++; $display("FAIL viol_total: got %0d expected 2", n);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] cv, dv;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    int n;
    cv = {$urandom, $urandom};
    dv = {$urandom, $urandom};
    do_reset();
    bus.out_enq__RDY = 1'b0;
    bus.in_enq__ENA  = 4'b0111;
    bus.in_enq_v     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    tick();
    bus.in_enq__ENA = '0;
    tick();
    n_checks++;
    if (bus.in_enq__RDY !== 4'b1001) begin
      n_fail++; $display("FAIL rmid_refill_rdy: got %b expected 1001", bus.in_enq__RDY);
    end
    bus.in_enq__ENA = 4'b0001;
    tick();
    nRST = 1'b0;
    bus.in_enq__ENA  = '1;
    bus.out_enq__RDY = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (bus.out_enq__ENA !== 1'b0) begin
      n_fail++; $display("FAIL rmid_ena_in_reset: got %b expected 0", bus.out_enq__ENA);
    end
    tick();
    nRST = 1'b1;
    bus.in_enq__ENA = 4'b1001;
    bus.in_enq_v[0 +: DW]    = cv;
    bus.in_enq_v[3*DW +: DW] = dv;
    @(negedge CLK);
    n_checks++;
    if (bus.in_enq__RDY !== 4'b1111 || bus.out_enq__ENA !== 1'b0 || bus.sent_count !== 32'd0) begin
      n_fail++; $display("FAIL rmid_after_reset: got rdy=%b ena=%b count=%0d expected rdy=1111 ena=0 count=0",
                         bus.in_enq__RDY, bus.out_enq__ENA, bus.sent_count);
    end
    tick();
    bus.in_enq__ENA = '0;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (bus.out_enq__ENA === 1'b1) begin
        tag  = bus.out_enq_v[DW +: TW];
        data = bus.out_enq_v[DW-1:0];
        n_checks++;
        if (n == 0 && (c != 1 || tag !== 16'd1 || data !== cv)) begin
          n_fail++; $display("FAIL rmid_first: got c=%0d tag=%0d data=%h expected c=1 tag=1 data=%h", c, tag, data, cv);
        end else if (n == 1 && (tag !== 16'd4 || data !== dv)) begin
          n_fail++; $display("FAIL rmid_second: got tag=%0d data=%h expected tag=4 data=%h", tag, data, dv);
        end else if (n > 1) begin
          n_fail++; $display("FAIL rmid_stale: got tag=%0d data=%h expected no more messages", tag, data);
        end
        n++;
      end
      tick();
    end
    n_checks++;
    if (n != 2) begin
      n_fail++; $display("FAIL rmid_total: got %0d expected 2", n);
    end
  endtask

  task automatic test_random();
    int total, pushed, r, left;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    total = 0;
    do_reset();
    for (int cyc = 0; cyc < 3050; cyc++) begin
      if (cyc < 3000) begin
        offer(NREQ'($urandom), pushed);
        total += pushed;
        bus.out_enq__RDY = ($urandom_range(0, 9) < 7);
      end else begin
        bus.in_enq__ENA  = '0;
        bus.out_enq__RDY = 1'b1;
      end
      @(negedge CLK);
      if (bus.out_enq__ENA === 1'b1) begin
        tag  = bus.out_enq_v[DW +: TW];
        data = bus.out_enq_v[DW-1:0];
        r = int'(tag) - 1;
        n_checks++;
        if (r < 0 || r >= NREQ || exp_q[r].size() == 0) begin
          n_fail++; $display("FAIL rand_tag: got tag=%0d data=%h expected a pending requester tag", tag, data);
        end else begin
          if (data !== exp_q[r][0]) begin
            n_fail++; $display("FAIL rand_data tag%0d: got %h expected %h", tag, data, exp_q[r][0]);
          end
          void'(exp_q[r].pop_front());
        end
      end
      tick();
    end
    left = 0;
    for (int i = 0; i < NREQ; i++) left += exp_q[i].size();
    n_checks++;
    if (left != 0) begin
      n_fail++; $display("FAIL rand_drain: got %0d undelivered expected 0", left);
    end
    n_checks++;
    if (bus.sent_count !== 32'(total)) begin
      n_fail++; $display("FAIL rand_sent_count: got %0d expected %0d", bus.sent_count, total);
    end
  endtask

  initial begin
    nRST = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_violation();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
